// File: rtl/spi_peripheral_pkg.sv
// Shared constants for the SPI register slave: register map addresses,
// frame length and the receive FSM state encoding.
package spi_regs_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  // 1 R/W bit + 7 address bits + 8 data bits
  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_peripheral_if.sv
// Bundle of the SPI pins and the five PWM control register outputs.
//   sclk, copi, ncs  : SPI pins, asynchronous to the system clock
//   en_reg_*         : output / PWM enable registers
//   pwm_duty_cycle   : shared duty cycle register
// master: drives the pins and observes the registers (bus owner / bench)
// slave : the register peripheral
interface spi_peripheral_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
           en_reg_pwm_15_8, pwm_duty_cycle
  );

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
           en_reg_pwm_15_8, pwm_duty_cycle
  );
endinterface

// File: rtl/spi_peripheral_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, followed by one history
// flop so that rising and falling edges of the synchronized level can be seen.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   sync       : synchronized level
//   rise, fall : single-cycle edge strobes on the synchronized level
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign sync = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only slave owning the five PWM control registers.
//   clk, rst_n : system clock, async active-low reset
//   bus        : SPI pins in, register values out (spi_peripheral_if.slave)
//
//   state  | meaning
//   IDLE   | ncs high, waiting for ncs fall; sclk ignored
//   RECV   | shifting copi on each sclk rise, counting bits
//   COMMIT | one cycle: write register if the frame is a valid write
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input logic             clk,
  input logic             rst_n,
  spi_peripheral_if.slave bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RECV   = RECV;
  localparam logic [1:0] S_COMMIT = COMMIT;
  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_OVF  = 5'(FRAME_BITS + 1);

  logic sclk_rise, sclk_sync_unused, sclk_fall_unused;
  logic copi_sync, copi_rise_unused, copi_fall_unused;
  logic ncs_rise, ncs_fall, ncs_sync_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(bus.sclk),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(bus.copi),
    .sync(copi_sync), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(bus.ncs),
    .sync(ncs_sync_unused), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic [1:0]            state;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic [6:0]            frame_addr;
  logic [7:0]            frame_data;
  logic                  frame_ok;

  assign frame_addr = shift_q[FRAME_BITS-2 -: 7];
  assign frame_data = shift_q[7:0];
  // Counter saturates one past a full frame, so any long frame fails this test.
  assign frame_ok   = (bit_cnt == CNT_FULL) && shift_q[FRAME_BITS-1] &&
                      (frame_addr <= 7'(MAX_ADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ncs_fall) begin
            bit_cnt <= '0;
            shift_q <= '0;
            state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (ncs_rise) begin
            state <= S_COMMIT;
          end else if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_sync};
            if (bit_cnt != CNT_OVF) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        // An ncs fall seen here is dropped: IDLE only reacts to a fresh edge.
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.en_reg_out_7_0  <= 8'h00;
      bus.en_reg_out_15_8 <= 8'h00;
      bus.en_reg_pwm_7_0  <= 8'h00;
      bus.en_reg_pwm_15_8 <= 8'h00;
      bus.pwm_duty_cycle  <= 8'h00;
    end else if (state == S_COMMIT && frame_ok) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: bus.en_reg_out_7_0  <= frame_data;
        ADDR_EN_OUT_HI: bus.en_reg_out_15_8 <= frame_data;
        ADDR_EN_PWM_LO: bus.en_reg_pwm_7_0  <= frame_data;
        ADDR_EN_PWM_HI: bus.en_reg_pwm_15_8 <= frame_data;
        ADDR_DUTY:      bus.pwm_duty_cycle  <= frame_data;
        default: ;
      endcase
    end
  end

endmodule
